// File: rtl/test_pattern_pkg.sv
// ----------------------------------------------------------------------------
// test_pattern_pkg: pattern mode encodings shared by the test pattern painter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package test_pattern_pkg;

  localparam int NUM_MODES = 5;
  localparam int MODE_W    = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADDRESS  = 3'd0,
    MODE_WALK_COL = 3'd1,
    MODE_WALK_ROW = 3'd2,
    MODE_GRADIENT = 3'd3,
    MODE_CHECKER  = 3'd4
  } mode_e;

  // Codes 5-7 are never produced; the last pattern wraps to the first.
  function automatic mode_e next_mode(input mode_e m);
    return (m == MODE_CHECKER) ? MODE_ADDRESS : mode_e'(m + 3'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tp_sequencer.sv
// ----------------------------------------------------------------------------
// tp_sequencer: frame-tick detect, hold counter, pattern mode and walk position
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tp_sequencer
  import test_pattern_pkg::*;
#(
  parameter int FRAME_BITS  = 13,
  parameter int HOLD_FRAMES = 256,
  parameter int POS_BITS    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  auto_cycle,
  input  logic                  advance,
  output mode_e                 mode,
  output logic [POS_BITS-1:0]   walk_pos
);

  localparam int                HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  logic [FRAME_BITS-1:0] prev_frame_q, prev_frame_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  mode_e                 mode_q, mode_d;
  logic [POS_BITS-1:0]   walk_pos_q, walk_pos_d;
  logic                  tick;
  logic                  expire;
  logic                  step;

  always_comb begin
    prev_frame_d = frame;
    hold_cnt_d   = hold_cnt_q;
    mode_d       = mode_q;
    walk_pos_d   = walk_pos_q;

    tick   = (frame != prev_frame_q);
    expire = tick && auto_cycle && (hold_cnt_q == HOLD_LAST);
    // Advance and expiry together still produce a single step.
    step   = advance || expire;

    if (step) begin
      mode_d     = next_mode(mode_q);
      hold_cnt_d = '0;
      walk_pos_d = '0;
    end else begin
      if (tick && auto_cycle) hold_cnt_d = hold_cnt_q + 1'b1;
      if (tick)               walk_pos_d = walk_pos_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_frame_q <= '0;
      hold_cnt_q   <= '0;
      mode_q       <= MODE_ADDRESS;
      walk_pos_q   <= '0;
    end else begin
      prev_frame_q <= prev_frame_d;
      hold_cnt_q   <= hold_cnt_d;
      mode_q       <= mode_d;
      walk_pos_q   <= walk_pos_d;
    end
  end

  assign mode     = mode_q;
  assign walk_pos = walk_pos_q;

endmodule

`default_nettype wire

// File: rtl/test_pattern_painter.sv
// ----------------------------------------------------------------------------
// test_pattern_painter: registered five-pattern diagnostic painter, one pixel/cycle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module test_pattern_painter
  import test_pattern_pkg::*;
#(
  parameter int WIDTH_BITS  = 6,
  parameter int HEIGHT_BITS = 6,
  parameter int COLOR_BITS  = 1,
  parameter int FRAME_BITS  = 13,
  parameter int HOLD_FRAMES = 256,
  parameter int CHECK_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FRAME_BITS-1:0]   frame,
  input  logic [WIDTH_BITS-1:0]   x,
  input  logic [HEIGHT_BITS-1:0]  y,
  input  logic                    auto_cycle,
  input  logic                    advance,
  output logic [3*COLOR_BITS-1:0] rgb,
  output logic [MODE_W-1:0]       mode
);

  localparam int POS_BITS = (WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS;

  mode_e                   seq_mode;
  logic [POS_BITS-1:0]     walk_pos;
  logic [COLOR_BITS-1:0]   red, green, blue;
  logic                    x_pow2, y_pow2, on_edge;
  logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;

  tp_sequencer #(
    .FRAME_BITS  (FRAME_BITS),
    .HOLD_FRAMES (HOLD_FRAMES),
    .POS_BITS    (POS_BITS)
  ) u_sequencer (
    .clk        (clk),
    .reset      (reset),
    .frame      (frame),
    .auto_cycle (auto_cycle),
    .advance    (advance),
    .mode       (seq_mode),
    .walk_pos   (walk_pos)
  );

  always_comb begin
    red   = '0;
    green = '0;
    blue  = '0;

    x_pow2  = (x != '0) && ((x & (x - 1'b1)) == '0);
    y_pow2  = (y != '0) && ((y & (y - 1'b1)) == '0);
    on_edge = (x == '0) || (x == '1) || (y == '0) || (y == '1);

    case (seq_mode)
      MODE_ADDRESS: begin
        red   = {COLOR_BITS{x_pow2}};
        green = {COLOR_BITS{y_pow2}};
        blue  = {COLOR_BITS{on_edge}};
      end
      MODE_WALK_COL: begin
        red   = {COLOR_BITS{x == walk_pos[WIDTH_BITS-1:0]}};
        green = red;
        blue  = red;
      end
      MODE_WALK_ROW: begin
        red   = {COLOR_BITS{y == walk_pos[HEIGHT_BITS-1:0]}};
        green = red;
        blue  = red;
      end
      MODE_GRADIENT: begin
        red   = x[WIDTH_BITS-1 -: COLOR_BITS];
        green = y[HEIGHT_BITS-1 -: COLOR_BITS];
        blue  = walk_pos[POS_BITS-1 -: COLOR_BITS];
      end
      MODE_CHECKER: begin
        red   = {COLOR_BITS{x[CHECK_SHIFT] ^ y[CHECK_SHIFT]}};
        green = red;
        blue  = red;
      end
      default: ;
    endcase

    rgb_d = {blue, green, red};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign rgb  = rgb_q;
  assign mode = seq_mode;

endmodule

`default_nettype wire

// File: tb/tb_test_pattern_painter.sv
// ----------------------------------------------------------------------------
// tb_test_pattern_painter: directed scoreboard bench, 1-bit and 4-bit colour DUTs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_test_pattern_painter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] frame;
  logic [5:0]  x;
  logic [5:0]  y;
  logic        auto_cycle;
  logic        advance;
  logic [2:0]  rgb1;
  logic [11:0] rgb4;
  logic [2:0]  mode1;
  logic [2:0]  mode4;

  int n_cmp = 0;
  int n_err = 0;

  int m_mode = 0;
  int m_walk = 0;
  int m_hold = 0;

  logic [11:0] q1[$];
  logic [11:0] q4[$];

  always #5 clk = ~clk;

  test_pattern_painter #(
    .WIDTH_BITS(6), .HEIGHT_BITS(6), .COLOR_BITS(1),
    .FRAME_BITS(13), .HOLD_FRAMES(4), .CHECK_SHIFT(3)
  ) dut1 (
    .clk(clk), .reset(reset), .frame(frame), .x(x), .y(y),
    .auto_cycle(auto_cycle), .advance(advance), .rgb(rgb1), .mode(mode1)
  );

  test_pattern_painter #(
    .WIDTH_BITS(6), .HEIGHT_BITS(6), .COLOR_BITS(4),
    .FRAME_BITS(13), .HOLD_FRAMES(4), .CHECK_SHIFT(3)
  ) dut4 (
    .clk(clk), .reset(reset), .frame(frame), .x(x), .y(y),
    .auto_cycle(auto_cycle), .advance(advance), .rgb(rgb4), .mode(mode4)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference pixel colour from the pattern definitions, packed {blue, green, red}.
  function automatic logic [11:0] exp_rgb(input int cb, input int md, input int wk,
                                          input int px, input int py);
    int full, r, g, b;
    full = (1 << cb) - 1;
    r = 0; g = 0; b = 0;
    case (md)
      0: begin
        r = (px != 0 && (px & (px - 1)) == 0) ? full : 0;
        g = (py != 0 && (py & (py - 1)) == 0) ? full : 0;
        b = (px == 0 || px == 63 || py == 0 || py == 63) ? full : 0;
      end
      1: begin r = (px == wk) ? full : 0; g = r; b = r; end
      2: begin r = (py == wk) ? full : 0; g = r; b = r; end
      3: begin r = px >> (6 - cb); g = py >> (6 - cb); b = wk >> (6 - cb); end
      4: begin r = (((px >> 3) ^ (py >> 3)) & 1) ? full : 0; g = r; b = r; end
      default: ;
    endcase
    return 12'((b << (2 * cb)) | (g << cb) | r);
  endfunction

  // One pixel: expectations queued at drive time, checked when the registered output appears.
  task automatic pix(input int px, input int py);
    x = 6'(px);
    y = 6'(py);
    q1.push_back(exp_rgb(1, m_mode, m_walk, px, py));
    q4.push_back(exp_rgb(4, m_mode, m_walk, px, py));
    @(posedge clk);
    #1;
    chk($sformatf("rgb1(%0d,%0d)", px, py), {9'b0, rgb1}, q1.pop_front());
    chk($sformatf("rgb4(%0d,%0d)", px, py), rgb4, q4.pop_front());
  endtask

  // One cycle with an optional frame tick and/or advance pulse.
  task automatic cyc(input bit t, input bit a);
    bit expire, step;
    if (t) frame = frame + 1'b1;
    advance = a;
    @(posedge clk);
    #1;
    advance = 1'b0;
    expire = t && auto_cycle && (m_hold == 3);
    step   = a || expire;
    if (step) begin
      m_mode = (m_mode + 1) % 5;
      m_hold = 0;
      m_walk = 0;
    end else begin
      if (t && auto_cycle) m_hold++;
      if (t) m_walk = (m_walk + 1) % 64;
    end
    chk("mode1", {9'b0, mode1}, 12'(m_mode));
    chk("mode4", {9'b0, mode4}, 12'(m_mode));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    frame      = '0;
    x          = '0;
    y          = '0;
    auto_cycle = 1'b0;
    advance    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb1", {9'b0, rgb1}, 12'h000);
    chk("reset_rgb4", rgb4, 12'h000);
    chk("reset_mode1", {9'b0, mode1}, 12'h000);
    reset = 1'b0;

    // Address pattern
    pix(8, 0);
    pix(5, 63);
    pix(6, 12);
    pix(63, 32);

    // Walking column at position 0, then asynchronous reset with output lit
    cyc(0, 1);
    pix(7, 5);
    pix(0, 5);
    reset = 1'b1;
    #1;
    chk("async_rst_rgb1", {9'b0, rgb1}, 12'h000);
    chk("async_rst_rgb4", rgb4, 12'h000);
    chk("async_rst_mode", {9'b0, mode1}, 12'h000);
    @(posedge clk);
    #1;
    chk("held_rst_rgb4", rgb4, 12'h000);
    chk("held_rst_mode", {9'b0, mode4}, 12'h000);
    reset  = 1'b0;
    m_mode = 0;
    m_walk = 0;
    m_hold = 0;

    // Two advances to walking row, three frame ticks -> row 3
    cyc(0, 1);
    cyc(0, 1);
    repeat (3) cyc(1, 0);
    pix(10, 3);
    pix(10, 2);
    pix(3, 10);
    pix(0, 3);

    // Gradient, then checker, then wrap back to address
    cyc(0, 1);
    pix(42, 21);
    pix(63, 0);
    cyc(0, 1);
    pix(8, 0);
    pix(8, 8);
    pix(0, 0);
    pix(15, 7);
    cyc(0, 1);
    pix(5, 63);

    // Auto cycling: 4 ticks per step, 20 ticks back to mode 0
    auto_cycle = 1'b1;
    repeat (4) cyc(1, 0);
    pix(0, 9);
    pix(1, 9);
    repeat (16) cyc(1, 0);

    // Advance coincident with expiry: one step, hold restarts from zero
    repeat (3) cyc(1, 0);
    cyc(1, 1);
    repeat (3) cyc(1, 0);
    cyc(1, 0);

    // auto_cycle low freezes the hold count
    repeat (2) cyc(1, 0);
    auto_cycle = 1'b0;
    repeat (5) cyc(1, 0);
    auto_cycle = 1'b1;
    cyc(1, 0);
    cyc(1, 0);
    pix(42, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
